// File: rtl/apb_ram_param.sv
// apb_ram_param: parametrised APB4 slave RAM with byte strobes, programmable
// wait states and error responses for misaligned / out-of-range accesses.
//
// Ports:
//   pclk     in   APB clock, rising edge
//   preset   in   asynchronous active-high reset (clears FSM, outputs, memory)
//   psel     in   slave select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address [ADDR_WIDTH]
//   pwdata   in   write data [DATA_WIDTH]
//   pstrb    in   write byte-lane enables [STRB_W]
//   prdata   out  registered read data, nonzero only with pready on a read
//   pready   out  registered transfer-complete pulse (one cycle)
//   pslverr  out  registered error response, only with pready
module apb_ram_param #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_W-1:0]     pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WCNT_W = 4;
  // Range compare is done wider than paddr so no address can wrap onto a valid word.
  localparam int unsigned CMP_W  = ADDR_WIDTH + 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state;
  logic [WCNT_W-1:0]     wcnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  misaligned_c;
  logic                  out_of_range_c;
  logic [IDX_W-1:0]      idx_c;

  // Decode of the address latched in the setup phase.
  assign misaligned_c   = (addr_q & ADDR_WIDTH'(STRB_W - 1)) != '0;
  assign out_of_range_c = CMP_W'(addr_q >> OFF_W) >= CMP_W'(DEPTH);
  assign idx_c          = addr_q[OFF_W +: IDX_W];

  // Transfer FSM, memory array and registered response.
  // The result is computed on the execute edge and presented one edge later
  // from RESP, so pready never depends combinationally on the bus inputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= IDLE;
      wcnt    <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          if (psel && !penable) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            wcnt    <= WCNT_W'(WAIT_STATES);
            state   <= ACCESS;
          end
        end

        ACCESS: begin
          if (!(psel && penable)) begin
            state <= IDLE;
          end else if (wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
          end else begin
            state <= RESP;
            if (misaligned_c || out_of_range_c) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              err_q <= 1'b0;
              if (write_q) begin
                rdata_q <= '0;
                for (int unsigned b = 0; b < STRB_W; b++) begin
                  if (strb_q[b]) begin
                    mem[idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
                  end
                end
              end else begin
                rdata_q <= mem[idx_c];
              end
            end
          end
        end

        RESP: begin
          pready  <= 1'b1;
          pslverr <= err_q;
          prdata  <= rdata_q;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_ram_param.sv
// Bench for apb_ram_param: two instances (0 and 3 wait states) share one APB
// master. A transaction-level model predicts, per instance, the cycle of the
// pready pulse and its pslverr/prdata; a negedge process compares every cycle.
module tb_apb_ram_param;

  localparam int WS0   = 0;
  localparam int WS1   = 3;
  localparam int WSMAX = 3;
  localparam int NONE  = 100;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;

  apb_ram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(WS0)) u_ws0 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  apb_ram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(WS1)) u_ws3 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model memory per instance; an aborted write may land in one but not the other.
  logic [31:0] mem_m [2][32];
  // Expected responses keyed by cycle: {check_data, err, data}.
  logic [33:0] sched0 [int];
  logic [33:0] sched1 [int];
  // Hand-written literal expectations keyed by cycle.
  logic [33:0] pin0 [int];
  logic [33:0] pin1 [int];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level behaviour: word = addr/4, valid if aligned and word < 32.
  function automatic logic [33:0] model_exec(input int k, input bit wr, input logic [31:0] addr,
                                             input logic [31:0] data, input logic [3:0] strb);
    int unsigned widx;
    widx = addr / 4;
    if ((addr % 4) != 0 || widx >= 32) return {1'b1, 1'b1, 32'h0};
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem_m[k][widx][8*b +: 8] = data[8*b +: 8];
      return {1'b0, 1'b0, 32'h0};
    end
    return {1'b1, 1'b0, mem_m[k][widx]};
  endfunction

  task automatic cmp_dut(input int k, input logic rdy, input logic err, input logic [31:0] data);
    logic [33:0] e;
    bit has, has_pin;
    logic [33:0] p;
    has     = (k == 0) ? sched0.exists(cyc) : sched1.exists(cyc);
    has_pin = (k == 0) ? pin0.exists(cyc) : pin1.exists(cyc);
    if (has) e = (k == 0) ? sched0[cyc] : sched1[cyc];
    if (has_pin) p = (k == 0) ? pin0[cyc] : pin1[cyc];
    if (preset || !has) begin
      chk($sformatf("dut%0d_quiet", k), {30'h0, rdy, err, data}, 64'h0);
    end else begin
      chk($sformatf("dut%0d_pready", k), 64'(rdy), 64'h1);
      chk($sformatf("dut%0d_pslverr", k), 64'(err), 64'(e[32]));
      if (e[33]) chk($sformatf("dut%0d_prdata", k), 64'(data), 64'(e[31:0]));
    end
    if (!preset && has_pin) begin
      chk($sformatf("dut%0d_pin_pready", k), 64'(rdy), 64'h1);
      chk($sformatf("dut%0d_pin_pslverr", k), 64'(err), 64'(p[32]));
      if (p[33]) chk($sformatf("dut%0d_pin_prdata", k), 64'(data), 64'(p[31:0]));
    end
  endtask

  // Every-cycle compare, sampled mid-cycle away from the active edge.
  always @(negedge pclk) begin
    cmp_dut(0, pready0, pslverr0, prdata0);
    cmp_dut(1, pready1, pslverr1, prdata1);
  end

  task automatic clear_model();
    sched0.delete(); sched1.delete(); pin0.delete(); pin1.delete();
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 32; w++) mem_m[k][w] = 32'h0;
  endtask

  // One APB transfer. The access phase is held for the slower instance; psel
  // drops before access edge abort_j (NONE = never). Bus fields are scrambled
  // during the access phase since only setup-phase values may matter.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int abort_j,
                       input bit pin_en, input logic [33:0] p0, input logic [33:0] p1);
    int e0;
    int ws;
    logic [33:0] r;
    @(posedge pclk); #2;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    e0 = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      ws = (k == 0) ? WS0 : WS1;
      if (abort_j > ws) begin
        r = model_exec(k, wr, addr, data, strb);
        if (k == 0) sched0[e0 + ws + 2] = r; else sched1[e0 + ws + 2] = r;
        if (pin_en) begin
          chk($sformatf("model%0d_vs_literal", k), 64'(r), 64'((k == 0) ? p0 : p1));
          if (k == 0) pin0[e0 + ws + 2] = p0; else pin1[e0 + ws + 2] = p1;
        end
      end
    end
    for (int j = 0; j <= WSMAX + 2; j++) begin
      @(posedge pclk); #2;
      psel    = (j < abort_j);
      penable = psel;
      paddr   = $urandom;
      pwdata  = $urandom;
      pstrb   = 4'($urandom);
      pwrite  = 1'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #2;
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  logic [31:0] ra;
  int          sel;

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    clear_model();
    repeat (3) @(posedge pclk);
    #2 preset = 1'b0;
    idle(2);

    // Reset mid-write: setup of a write, then reset during its access phase.
    @(posedge pclk); #2;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hDEADBEEF; pstrb = 4'hF;
    @(posedge pclk); #2;
    penable = 1'b1; preset = 1'b1;
    clear_model();
    #1;
    chk("reset_immediate", {30'h0, pready0, pslverr0, pready1, pslverr1}, 64'h0);
    chk("reset_prdata", {prdata0, prdata1}, 64'h0);
    repeat (3) @(posedge pclk);
    #2 preset = 1'b0; psel = 1'b0; penable = 1'b0;
    idle(1);
    issue(1'b0, 32'h8, 32'h0, 4'h0, NONE, 1'b1, {1'b1, 1'b0, 32'h0}, {1'b1, 1'b0, 32'h0});

    // Full-word write/read at the last word.
    issue(1'b1, 32'h7C, 32'hA5A51234, 4'hF, NONE, 1'b0, '0, '0);
    issue(1'b0, 32'h7C, 32'h0, 4'h0, NONE, 1'b1, {1'b1, 1'b0, 32'hA5A51234}, {1'b1, 1'b0, 32'hA5A51234});

    // Byte strobes.
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, NONE, 1'b0, '0, '0);
    issue(1'b1, 32'h10, 32'h11223344, 4'b0101, NONE, 1'b0, '0, '0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, NONE, 1'b1, {1'b1, 1'b0, 32'hFF22FF44}, {1'b1, 1'b0, 32'hFF22FF44});

    // Error responses; the out-of-range write must not alias onto word 0.
    issue(1'b1, 32'h80, 32'hCAFEF00D, 4'hF, NONE, 1'b1, {1'b1, 1'b1, 32'h0}, {1'b1, 1'b1, 32'h0});
    issue(1'b0, 32'h0, 32'h0, 4'h0, NONE, 1'b1, {1'b1, 1'b0, 32'h0}, {1'b1, 1'b0, 32'h0});
    issue(1'b0, 32'h6, 32'h0, 4'h0, NONE, 1'b1, {1'b1, 1'b1, 32'h0}, {1'b1, 1'b1, 32'h0});
    issue(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, NONE, 1'b1, {1'b1, 1'b1, 32'h0}, {1'b1, 1'b1, 32'h0});

    // Word 5 with paddr scrambled during the wait states.
    issue(1'b1, 32'h14, 32'h5555AAAA, 4'hF, NONE, 1'b0, '0, '0);
    issue(1'b0, 32'h14, 32'h0, 4'h0, NONE, 1'b1, {1'b1, 1'b0, 32'h5555AAAA}, {1'b1, 1'b0, 32'h5555AAAA});

    // Access phase with no setup phase: must never complete.
    idle(1);
    @(posedge pclk); #2;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h12345678; pstrb = 4'hF;
    repeat (10) @(posedge pclk);
    #2 psel = 1'b0; penable = 1'b0;
    idle(1);

    // psel dropped in the wait states: the 3-wait instance drops the write,
    // the 0-wait instance has already executed it.
    issue(1'b1, 32'h20, 32'h12345678, 4'hF, NONE, 1'b0, '0, '0);
    issue(1'b1, 32'h20, 32'hBAD0BAD0, 4'hF, 2, 1'b0, '0, '0);
    idle(1);
    issue(1'b0, 32'h20, 32'h0, 4'h0, NONE, 1'b1, {1'b1, 1'b0, 32'hBAD0BAD0}, {1'b1, 1'b0, 32'h12345678});

    // Randomised traffic, back-to-back or with short gaps.
    repeat (150) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       ra = 32'($urandom_range(0, 31)) * 4;
      else if (sel == 7) ra = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) ra = 32'h80 + 32'($urandom_range(0, 1000)) * 4;
      else               ra = $urandom;
      issue(1'($urandom), ra, $urandom, 4'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : NONE,
            1'b0, '0, '0);
      idle($urandom_range(0, 2));
    end

    idle(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
